// File: rtl/request_conditioner_pkg.sv
// Shared definitions for the request conditioner: default debounce
// parameters and the channel indices used to address the per-channel
// vectors in the top level.
package request_conditioner_pkg;

    // Default number of consecutive differing cycles before a level flips.
    localparam int DB_COUNT_DEFAULT = 1000;

    // Default width of each debounce counter.
    localparam int CNT_W_DEFAULT = 10;

    // Channel indices into the 3-bit raw/stable/rise vectors.
    localparam int WALK   = 0;
    localparam int REPROG = 1;
    localparam int SENSOR = 2;

    localparam int NUM_CH = 3;

endpackage : request_conditioner_pkg

// File: rtl/request_conditioner_debounce_filter.sv
// Single-channel debounce filter.
// The debounced level flips only after the raw input has differed from it
// for DB_COUNT consecutive rising edges. Any edge where raw agrees with the
// debounced level restarts the count.
// Ports:
//   clk     - system clock, rising edge active
//   Reset_n - asynchronous active-low reset
//   raw     - synchronized input level
//   stable  - debounced level (register output)
//   rise    - debounced level is high this cycle and was low the cycle before
module debounce_filter #(
    parameter int DB_COUNT = 1000,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic raw,
    output logic stable,
    output logic rise
);

    // Terminal count value: reaching it with raw still differing flips the level.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_COUNT - 1);

    logic             stable_r;
    logic             prev_r;
    logic [CNT_W-1:0] cnt_r;

    // Debounce counter, debounced level and one-cycle delayed copy for edge detect.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stable_r <= 1'b0;
            prev_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            prev_r <= stable_r;
            if (raw == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == LAST_CNT) begin
                stable_r <= raw;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign stable = stable_r;
    // Both operands are registers, so rise carries no path from raw.
    assign rise   = stable_r & ~prev_r;

endmodule : debounce_filter

// File: rtl/request_conditioner.sv
// Conditions the synchronized operator inputs before the traffic-light FSM.
// Each input is debounced; the Reprogram button becomes a one-cycle pulse,
// and a walk press is latched until the FSM acknowledges it.
// Ports:
//   clk               - system clock, rising edge active
//   Reset_n           - asynchronous active-low reset
//   Walk_request_Sync - synchronized walk button
//   Reprogram_Sync    - synchronized reprogram button
//   Sensor_Sync       - synchronized vehicle sensor
//   Walk_ack          - one-cycle strobe from the FSM, walk request serviced
//   Walk_pending      - latched walk request, high until acknowledged
//   Reprogram_pulse   - one-cycle strobe per debounced Reprogram press
//   Sensor_stable     - debounced sensor level
module request_conditioner
    import request_conditioner_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic Walk_request_Sync,
    input  logic Reprogram_Sync,
    input  logic Sensor_Sync,
    input  logic Walk_ack,
    output logic Walk_pending,
    output logic Reprogram_pulse,
    output logic Sensor_stable
);

    logic [NUM_CH-1:0] raw_s;
    logic [NUM_CH-1:0] stable_s;
    logic              walk_rise_s;
    logic              reprog_rise_s;
    logic              sensor_rise_unused_s;
    logic              walk_pending_r;
    logic              reprog_pulse_r;

    assign raw_s[WALK]   = Walk_request_Sync;
    assign raw_s[REPROG] = Reprogram_Sync;
    assign raw_s[SENSOR] = Sensor_Sync;

    debounce_filter #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_walk_db (
        .clk     (clk),
        .Reset_n (Reset_n),
        .raw     (raw_s[WALK]),
        .stable  (stable_s[WALK]),
        .rise    (walk_rise_s)
    );

    debounce_filter #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_reprog_db (
        .clk     (clk),
        .Reset_n (Reset_n),
        .raw     (raw_s[REPROG]),
        .stable  (stable_s[REPROG]),
        .rise    (reprog_rise_s)
    );

    // Only the level of the sensor is of interest; its edge output is dropped.
    debounce_filter #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_sensor_db (
        .clk     (clk),
        .Reset_n (Reset_n),
        .raw     (raw_s[SENSOR]),
        .stable  (stable_s[SENSOR]),
        .rise    (sensor_rise_unused_s)
    );

    // Walk request latch and reprogram strobe; a new walk rise beats a
    // simultaneous acknowledge so that no press is ever lost.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            walk_pending_r <= 1'b0;
            reprog_pulse_r <= 1'b0;
        end else begin
            reprog_pulse_r <= reprog_rise_s;
            if (walk_rise_s) begin
                walk_pending_r <= 1'b1;
            end else if (Walk_ack) begin
                walk_pending_r <= 1'b0;
            end else begin
                walk_pending_r <= walk_pending_r;
            end
        end
    end

    assign Walk_pending    = walk_pending_r;
    assign Reprogram_pulse = reprog_pulse_r;
    assign Sensor_stable   = stable_s[SENSOR];

endmodule : request_conditioner
